gpr_ctrl: RTL and testbench
===========================

GPR_CTRL -- requirements
Module: gpr_ctrl

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of general-purpose registers tracked.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (log2 REG_NUM).
REQ-003 SHALL have parameter DATA_W, default 32, word data width.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0_valid / req0_addr / req0_data  input  1 / ADDR_W / DATA_W  ALU writeback request.
REQ-007 SHALL have ports req1_valid / req1_addr / req1_data  input  1 / ADDR_W / DATA_W  load-unit writeback request.
REQ-008 SHALL have ports req0_ready, req1_ready  output  1 each  grant; request accepted when valid and ready are both high at posedge.
REQ-009 SHALL have ports iss_valid / iss_addr  input  1 / ADDR_W  instruction issue; marks destination register pending.
REQ-010 SHALL have ports rd_en_0 / rd_addr_0, rd_en_1 / rd_addr_1  input  1 / ADDR_W each  source operands of the issuing instruction.
REQ-011 SHALL have port flush  input  1  pipeline flush; clears all pending marks.
REQ-012 SHALL have port stall  output  1  issue hazard; high when the issuing instruction must wait.
REQ-013 SHALL have ports gpr_we_ / gpr_wr_addr / gpr_wr_data  output  1 / ADDR_W / DATA_W  registered GPR write port; gpr_we_ active-low.

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_ready SHALL be combinational from valids and arbitration state and never high when reqN_valid is low.
REQ-015 SHALL load an accepted request into the output register at the accepting posedge: gpr_we_=0, gpr_wr_addr/gpr_wr_data = request fields one cycle later (latency 1); gpr_we_=1 in any cycle following no acceptance.
REQ-016 SHALL hold gpr_wr_addr/gpr_wr_data unchanged when no request is accepted.
REQ-017 SHALL keep a REG_NUM-bit busy vector: iss_valid && !stall sets busy[iss_addr]; acceptance of a request clears busy[reqN_addr] at the same posedge.
REQ-018 SHALL give set priority over clear when issue and writeback target the same register in the same cycle (busy stays 1).
REQ-019 SHALL accept and perform writes to registers not marked busy, with no error indication and no busy change.
REQ-020 SHALL drive stall = iss_valid && ((rd_en_0 && busy[rd_addr_0]) || (rd_en_1 && busy[rd_addr_1]) || busy[iss_addr]), combinational, covering RAW and WAW.
REQ-021 SHALL not treat a same-cycle accepted writeback as clearing busy for stall evaluation; the hazard clears the following cycle, when the GPR write-after-read forwarding supplies the value.
REQ-022 SHALL on flush clear the entire busy vector at the posedge, ignore iss_valid that cycle, and still accept and perform writebacks presented that cycle.
REQ-023 SHALL drive stall low while flush is high.

Reset
REQ-024 SHALL on reset low, asynchronously: gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, busy=all 0, round-robin pointer=0 (req0 favoured next).
REQ-025 SHALL discard any request in flight on reset mid-operation; no write SHALL be issued in the cycle after reset deassertion unless a request is accepted in the first active cycle.

Configuration
REQ-026 SHALL with GPR_CTRL_RR_EN defined use round-robin arbitration: on contention grant the requester indicated by the pointer, then point to the other; an uncontended grant SHALL also move the pointer to the other requester.
REQ-027 SHALL with GPR_CTRL_RR_EN undefined use fixed priority, req1 (load) over req0, with no pointer state.

Verification
REQ-028 SHALL check after reset release: gpr_we_=1, stall=0, busy all 0, both ready low with no valid.
REQ-029 SHALL check iss_valid=1, iss_addr=5, then rd_en_0=1, rd_addr_0=5 -> stall=1 until req0 (addr 5, data 0x1234_5678) accepted; next cycle stall=0, gpr_we_=0, gpr_wr_addr=5, gpr_wr_data=0x1234_5678.
REQ-030 SHALL check req0 and req1 both valid for 4 cycles: RR_EN -> grants 0,1,0,1; fixed -> grants 1,1,1,1 with req0_ready low throughout.
REQ-031 SHALL check iss_valid to addr 7 and req1 writeback to addr 7 in the same cycle -> busy[7] remains 1 and stall asserts for a following reader of 7.
REQ-032 SHALL check busy set on addrs 3 and 9, then flush=1 with req0 to addr 3 -> busy all 0, write to addr 3 still occurs next cycle, stall=0.
REQ-033 SHALL check reset asserted in the cycle a request is accepted -> gpr_we_=1 immediately and no write after deassertion.

Source files
------------

// File: rtl/gpr_ctrl.sv
// gpr_ctrl: GPR writeback arbiter with a busy scoreboard for RAW/WAW issue stalls.
// Define GPR_CTRL_RR_EN for round-robin arbitration; otherwise load (req1) has fixed priority.
module gpr_ctrl #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              rd_en_0,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic              rd_en_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic              flush,
  output logic              stall,
  output logic              gpr_we_,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data
);
  localparam logic [REG_NUM-1:0] ONE = {{(REG_NUM-1){1'b0}}, 1'b1};
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               r_we_n;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
`ifdef GPR_CTRL_RR_EN
  logic r_ptr;
  always_comb begin
    w_gnt1 = req1_valid && (!req0_valid || r_ptr);
    w_gnt0 = req0_valid && !w_gnt1;
  end
  // any grant hands priority to the other requester
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ptr <= 1'b0;
    else if (w_gnt0 || w_gnt1) r_ptr <= w_gnt0;
`else
  always_comb begin
    w_gnt1 = req1_valid;
    w_gnt0 = req0_valid && !req1_valid;
  end
`endif
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  // same-cycle writebacks do not unblock the hazard; forwarding covers it next cycle
  assign stall = !flush && iss_valid &&
                 ((rd_en_0 && r_busy[rd_addr_0]) || (rd_en_1 && r_busy[rd_addr_1]) || r_busy[iss_addr]);
  always_comb begin
    w_set = (iss_valid && !stall && !flush) ? (ONE << iss_addr) : '0;
    w_clr = (w_gnt0 ? (ONE << req0_addr) : '0) | (w_gnt1 ? (ONE << req1_addr) : '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_busy <= '0;
    else if (flush) r_busy <= '0;
    else r_busy <= (r_busy & ~w_clr) | w_set;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_we_n <= 1'b1;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we_n <= !(w_gnt0 || w_gnt1);
      if (w_gnt0 || w_gnt1) begin
        r_addr <= w_gnt1 ? req1_addr : req0_addr;
        r_data <= w_gnt1 ? req1_data : req0_data;
      end
    end
  assign gpr_we_     = r_we_n;
  assign gpr_wr_addr = r_addr;
  assign gpr_wr_data = r_data;
endmodule

// File: tb/tb_gpr_ctrl.sv
// tb_gpr_ctrl: directed bench for gpr_ctrl; builds with or without GPR_CTRL_RR_EN.
module tb_gpr_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid, req1_valid, iss_valid, rd_en_0, rd_en_1, flush;
  logic [4:0]  req0_addr, req1_addr, iss_addr, rd_addr_0, rd_addr_1;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, stall, gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;
  int n_tests = 0;
  int n_fail = 0;

  gpr_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rd_en_0(rd_en_0), .rd_addr_0(rd_addr_0), .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1),
    .flush(flush), .stall(stall),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    iss_valid = 0; iss_addr = 0; rd_en_0 = 0; rd_addr_0 = 0; rd_en_1 = 0; rd_addr_1 = 0;
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    idle();
    tick(); tick();
    n_tests++; if (gpr_we_ !== 1'b1) begin n_fail++; $display("FAIL rst_held_we got %b want 1", gpr_we_); end
    reset = 1;
    #1;
    n_tests++; if (gpr_we_ !== 1'b1) begin n_fail++; $display("FAIL rst_we got %b want 1", gpr_we_); end
    n_tests++; if (gpr_wr_addr !== 5'd0 || gpr_wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_wr got %h/%h want 0/0", gpr_wr_addr, gpr_wr_data); end
    n_tests++; if (dut.r_busy !== 32'd0) begin n_fail++; $display("FAIL rst_busy got %h want 0", dut.r_busy); end
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b want 00", req0_ready, req1_ready); end
    iss_valid = 1; iss_addr = 0; rd_en_0 = 1; rd_addr_0 = 0; rd_en_1 = 1; rd_addr_1 = 31;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
    idle();
  endtask

  task automatic test_raw();
    tick();
    iss_valid = 1; iss_addr = 5;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue_stall got %b want 0", stall); end
    tick();
    iss_addr = 10; rd_en_0 = 1; rd_addr_0 = 5;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %b want 1", stall); end
    tick();
    n_tests++; if (stall !== 1'b1 || gpr_we_ !== 1'b1) begin n_fail++; $display("FAIL raw_wait got stall=%b we_=%b want 1/1", stall, gpr_we_); end
    req0_valid = 1; req0_addr = 5; req0_data = 32'h1234_5678;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL raw_accept_cycle got rdy=%b stall=%b want 1/1", req0_ready, stall); end
    tick();
    req0_valid = 0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got %b want 0", stall); end
    n_tests++; if (gpr_we_ !== 1'b0 || gpr_wr_addr !== 5'd5 || gpr_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL raw_write got %b/%h/%h want 0/05/12345678", gpr_we_, gpr_wr_addr, gpr_wr_data); end
    idle();
    tick();
    n_tests++; if (gpr_we_ !== 1'b1 || gpr_wr_addr !== 5'd5 || gpr_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL raw_hold got %b/%h/%h want 1/05/12345678", gpr_we_, gpr_wr_addr, gpr_wr_data); end
  endtask

  task automatic test_arbitration();
    logic exp1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef GPR_CTRL_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b1;
`endif
      req0_valid = 1; req0_addr = 1; req0_data = 32'hA0 + k;
      req1_valid = 1; req1_addr = 2; req1_data = 32'hB0 + k;
      #1;
      n_tests++; if (req1_ready !== exp1 || req0_ready !== !exp1) begin n_fail++; $display("FAIL arb_grant[%0d] got r0=%b r1=%b want r1=%b", k, req0_ready, req1_ready, exp1); end
      tick();
      n_tests++;
      if (gpr_we_ !== 1'b0 || gpr_wr_addr !== (exp1 ? 5'd2 : 5'd1) || gpr_wr_data !== (exp1 ? 32'hB0 + k : 32'hA0 + k)) begin
        n_fail++; $display("FAIL arb_write[%0d] got %b/%h/%h", k, gpr_we_, gpr_wr_addr, gpr_wr_data);
      end
    end
    idle();
    #1;
    n_tests++; if (dut.r_busy !== 32'd0) begin n_fail++; $display("FAIL arb_busy got %h want 0", dut.r_busy); end
  endtask

  task automatic test_set_over_clear();
    tick();
    iss_valid = 1; iss_addr = 7;
    req1_valid = 1; req1_addr = 7; req1_data = 32'h77;
    #1;
    n_tests++; if (stall !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL soc_cycle got stall=%b rdy=%b want 0/1", stall, req1_ready); end
    tick();
    idle();
    iss_valid = 1; iss_addr = 8; rd_en_1 = 1; rd_addr_1 = 7;
    #1;
    n_tests++; if (dut.r_busy[7] !== 1'b1) begin n_fail++; $display("FAIL soc_busy7 got %b want 1", dut.r_busy[7]); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL soc_raw_stall got %b want 1", stall); end
    n_tests++; if (gpr_we_ !== 1'b0 || gpr_wr_addr !== 5'd7 || gpr_wr_data !== 32'h77) begin n_fail++; $display("FAIL soc_write got %b/%h/%h want 0/07/77", gpr_we_, gpr_wr_addr, gpr_wr_data); end
    rd_en_1 = 0; iss_addr = 7;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL soc_waw_stall got %b want 1", stall); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    iss_valid = 1; iss_addr = 3;
    tick();
    iss_addr = 9;
    tick();
    n_tests++; if (dut.r_busy !== 32'h0000_0208) begin n_fail++; $display("FAIL flush_pre_busy got %h want 00000208", dut.r_busy); end
    flush = 1; iss_addr = 12; rd_en_0 = 1; rd_addr_0 = 9;
    req0_valid = 1; req0_addr = 3; req0_data = 32'hCAFE;
    #1;
    n_tests++; if (stall !== 1'b0 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cycle got stall=%b rdy=%b want 0/1", stall, req0_ready); end
    tick();
    flush = 0; req0_valid = 0;
    #1;
    n_tests++; if (dut.r_busy !== 32'd0) begin n_fail++; $display("FAIL flush_busy got %h want 0", dut.r_busy); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
    n_tests++; if (gpr_we_ !== 1'b0 || gpr_wr_addr !== 5'd3 || gpr_wr_data !== 32'hCAFE) begin n_fail++; $display("FAIL flush_write got %b/%h/%h want 0/03/cafe", gpr_we_, gpr_wr_addr, gpr_wr_data); end
    idle();
  endtask

  task automatic test_reset_mid();
    tick();
    req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
    tick();
    req0_addr = 6; req0_data = 32'h66;
    #1;
    n_tests++; if (gpr_we_ !== 1'b0 || gpr_wr_addr !== 5'd4) begin n_fail++; $display("FAIL mid_pre got %b/%h want 0/04", gpr_we_, gpr_wr_addr); end
    reset = 0;
    #1;
    n_tests++; if (gpr_we_ !== 1'b1 || gpr_wr_addr !== 5'd0 || gpr_wr_data !== 32'd0) begin n_fail++; $display("FAIL mid_async got %b/%h/%h want 1/00/0", gpr_we_, gpr_wr_addr, gpr_wr_data); end
    tick();
    n_tests++; if (gpr_we_ !== 1'b1) begin n_fail++; $display("FAIL mid_held got %b want 1", gpr_we_); end
    idle();
    reset = 1;
    tick();
    n_tests++; if (gpr_we_ !== 1'b1 || gpr_wr_addr !== 5'd0 || gpr_wr_data !== 32'd0) begin n_fail++; $display("FAIL mid_after got %b/%h/%h want 1/00/0", gpr_we_, gpr_wr_addr, gpr_wr_data); end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_arbitration();
    test_set_over_clear();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
